addsub_digit_serial: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes DIGIT bits per clock through one DIGIT-wide ripple slice, LSB digit first, with a registered carry between digits.
- Trades latency for area on wide operands. Used wherever a WIDTH-bit add/sub is needed once every few cycles.
- Adds a start/busy/done handshake, operand capture and a signed-overflow flag.

---
 rtl/addsub_digit_serial.sv | 141 ++++++++++++++
 tb/tb_addsub_digit_serial.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor.
// One DIGIT-wide ripple slice is reused K = WIDTH/DIGIT times, LSB digit first,
// with the carry registered between digits. Subtraction is A + ~B + 1, with the
// +1 supplied as the initial carry.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last completed result
// S_RUN   | one digit processed per clock; busy=1
// S_DONE  | single-cycle done pulse; start here begins a new run at once
module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_next;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic             msb_cin;

    // The last digit is the one processed when the counter reads K-1.
    assign last = (cnt == CW'(K - 1));

    // One ripple slice over the low digit of each operand register.
    assign slice = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of the slice, recovered from its sum bit; on the
    // last digit this is the carry into bit WIDTH-1 needed for overflow.
    assign msb_cin = slice[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

    // New result digit enters from the top so that after K digits the
    // register holds the full result in the right bit positions.
    assign r_next = (r_sr >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, digit processing and result loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{m}};
            r_sr  <= '0;
            carry <= m;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            r_sr  <= r_next;
            carry <= slice[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum  <= r_next;
                cout <= slice[DIGIT];
                ovf  <= msb_cin ^ slice[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: three instances (DIGIT=4, 16, 1) share one
// stimulus stream; a per-instance arithmetic model predicts every output each
// cycle, and directed operations also carry hand-computed literal results.
module tb_addsub_digit_serial;

    localparam int W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              m;

    logic [2:0]        busy_o;
    logic [2:0]        done_o;
    logic [2:0]        cout_o;
    logic [2:0]        ovf_o;
    logic [2:0][W-1:0] sum_o;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    int kval [3] = '{4, 1, 16};

    always #5 clk = ~clk;

    addsub_digit_serial #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));

    addsub_digit_serial #(.WIDTH(W), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));

    addsub_digit_serial #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]));

    // Reference arithmetic: plain integer add/sub, unsigned carry and signed range.
    function automatic void ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic mm, output logic [W-1:0] s,
                                     output logic c, output logic o);
        int sx, sy, r, ur;
        sx = $signed(x);
        sy = $signed(y);
        if (!mm) begin
            ur = int'(x) + int'(y);
            r  = sx + sy;
            c  = (ur > 65535);
        end else begin
            ur = int'(x) - int'(y);
            r  = sx - sy;
            c  = (x >= y);
        end
        s = ur[W-1:0];
        o = (r > 32767) || (r < -32768);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: remaining busy cycles per instance, done flag, expected outputs.
    int           mrem  [3];
    logic         mdone [3];
    logic [W-1:0] cap_a [3];
    logic [W-1:0] cap_b [3];
    logic         cap_m [3];
    logic [W-1:0] esum  [3];
    logic         ecout [3];
    logic         eovf  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mrem[i]  = 0;
                mdone[i] = 1'b0;
                esum[i]  = '0;
                ecout[i] = 1'b0;
                eovf[i]  = 1'b0;
            end else if (mrem[i] > 0) begin
                mrem[i]--;
                mdone[i] = 1'b0;
                if (mrem[i] == 0) begin
                    ref_calc(cap_a[i], cap_b[i], cap_m[i], esum[i], ecout[i], eovf[i]);
                    mdone[i] = 1'b1;
                end
            end else begin
                mdone[i] = 1'b0;
                if (start) begin
                    cap_a[i] = a;
                    cap_b[i] = b;
                    cap_m[i] = m;
                    mrem[i]  = kval[i];
                end
            end
        end
    end

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[k=%0d]", kval[i]), 32'(busy_o[i]), 32'(mrem[i] > 0));
                chk($sformatf("done[k=%0d]", kval[i]), 32'(done_o[i]), 32'(mdone[i]));
                chk($sformatf("sum[k=%0d]",  kval[i]), 32'(sum_o[i]),  32'(esum[i]));
                chk($sformatf("cout[k=%0d]", kval[i]), 32'(cout_o[i]), 32'(ecout[i]));
                chk($sformatf("ovf[k=%0d]",  kval[i]), 32'(ovf_o[i]),  32'(eovf[i]));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o != 3'b000 || done_o != 3'b000) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    // Launch one operation on all instances; returns the DIGIT=4 busy-cycle
    // count and leaves time at the negedge where its done is high.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic mm,
                          output int nbusy);
        int n;
        wait_idle();
        a = x; b = y; m = mm; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        m = 1'($urandom);
        nbusy = 0;
        n = 0;
        @(negedge clk);
        while (!done_o[0] && n < 40) begin
            if (busy_o[0]) nbusy++;
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic mm, input logic [W-1:0] es, input logic ec,
                           input logic eo);
        int nb;
        launch(x, y, mm, nb);
        chk({name, "_latency"}, 32'(nb), 32'd4);
        chk({name, "_sum"},  32'(sum_o[0]),  32'(es));
        chk({name, "_cout"}, 32'(cout_o[0]), 32'(ec));
        chk({name, "_ovf"},  32'(ovf_o[0]),  32'(eo));
    endtask

    initial begin
        int nb;
        int ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; m = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_sum",  32'(sum_o[0]), 32'd0);

        run_lit("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_lit("uwrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_lit("sovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_lit("sub_neg",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_lit("sovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_lit("sub_zero", 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0);

        // start held high with operands toggling every cycle: back-to-back runs,
        // each result tied to the operands present at its accepting edge.
        wait_idle();
        start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        start = 1'b0;
        chk("held_start_done_count", 32'(ndone), 32'd3);

        // Reset during RUN cycle 2 of the DIGIT=4 instance.
        run_lit("pre_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        wait_idle();
        a = 16'h4444; b = 16'h0101; m = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_sum",  32'(sum_o[0]),  32'd0);
        chk("rst_cout", 32'(cout_o[0]), 32'd0);
        chk("rst_ovf",  32'(ovf_o[0]),  32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        run_lit("post_rst", 16'h4444, 16'h0101, 1'b1, 16'h4343, 1'b1, 1'b0);

        // Random signed operands, both modes; the model checks all three widths.
        for (int t = 0; t < 40; t++) begin
            launch(W'($urandom), W'($urandom), 1'(t & 1), nb);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
